// File: rtl/vga_scanout_pkg.sv
// Shared definitions for the VGA read side of the 256x240 frame buffer.
// Holds the 640x480@60 timing constants, the sync windows derived from them,
// the horizontal picture window, the frame-buffer geometry and the packed
// 12-bit colour type. The frame-buffer writer imports the same geometry.
package vga_scanout_pkg;

    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_BP   = 10'd48;
    localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_LAST  = H_TOTAL - 10'd1;

    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_BP   = 10'd33;
    localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_LAST  = V_TOTAL - 10'd1;

    localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

    // 256 NES pixels doubled to 512 screen pixels, centred in 640
    localparam logic [9:0] H_OFF       = 10'd64;
    localparam logic [9:0] H_PIC_START = H_OFF;
    localparam logic [9:0] H_PIC_END   = H_OFF + 10'd511;

    localparam logic [15:0] FB_W    = 16'd256;
    localparam logic [15:0] FB_H    = 16'd240;
    localparam logic [19:0] FB_SIZE = 20'(FB_W) * 20'(FB_H);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Per-pixel flags carried down the pipeline next to the address/data path
    typedef struct packed {
        logic vis;
        logic pic;
        logic hs;
        logic vs;
        logic fs;
    } scan_flags_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port plus VGA pin bundle.
//   fb_index    : read address to the frame-buffer RAM (0..61439)
//   fb_data     : RAM word {R,G,B}, one clock after fb_index
//   vga_hs/vs   : active-low syncs
//   vga_r/g/b   : 4-bit colour pins
//   frame_start : one-clock pulse when pixel (0,0) is on the pins
// master = scanout block, slave = RAM/connector side.
interface vga_scanout_if;
    logic [19:0] fb_index;
    logic [11:0] fb_data;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;

    modport master (
        output fb_index, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start,
        input  fb_data
    );

    modport slave (
        input  fb_index, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start,
        output fb_data
    );
endinterface

// File: rtl/vga_timing.sv
// Raster counters for 640x480@60.
//   clk, rst  : pixel clock, async active-high reset
//   hc, vc    : current horizontal/vertical count (0..799, 0..524)
//   flags_now : visible/picture/sync/frame-start decode of the current count,
//               undelayed; the caller pipelines them to match its data path
module vga_timing
    import vga_scanout_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  hc,
    output logic [9:0]  vc,
    output scan_flags_t flags_now
);

    logic h_wrap;
    logic vis;

    assign h_wrap = (hc == H_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else begin
            hc <= h_wrap ? '0 : hc + 10'd1;
            if (h_wrap) begin
                vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
            end
        end
    end

    assign vis           = (hc < H_VIS) && (vc < V_VIS);
    assign flags_now.vis = vis;
    assign flags_now.pic = vis && (hc >= H_PIC_START) && (hc <= H_PIC_END);
    assign flags_now.hs  = (hc >= H_SYNC_START) && (hc <= H_SYNC_END);
    assign flags_now.vs  = (vc >= V_SYNC_START) && (vc <= V_SYNC_END);
    assign flags_now.fs  = (hc == 10'd0) && (vc == 10'd0);

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer scanout to VGA. Each frame-buffer pixel is doubled in both
// axes and centred with a 64-pixel border left and right.
//   clk, rst : 25 MHz pixel clock, async active-high reset
//   bus      : master side of vga_scanout_if (RAM read port + VGA pins)
//   BORDER   : colour shown in the visible area outside the picture
// Latency from raster count to pins is 3 clocks: address register, RAM
// output register, pin register. The flags ride a matching delay line.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter rgb12_t BORDER = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master bus
);

    logic [9:0]  hc;
    logic [9:0]  vc;
    scan_flags_t flags_now;
    scan_flags_t flags_d1;
    scan_flags_t flags_d2;
    logic [15:0] row_base;
    logic [7:0]  col;
    logic [19:0] fb_next;
    rgb12_t      rgb_q;

    vga_timing u_timing (
        .clk       (clk),
        .rst       (rst),
        .hc        (hc),
        .vc        (vc),
        .flags_now (flags_now)
    );

    assign col     = 8'((hc - H_PIC_START) >> 1);
    assign fb_next = flags_now.pic ? ({4'b0, row_base} + {12'b0, col}) : '0;

    // Row start address: advances one frame-buffer row every two screen
    // lines, cleared on the same edge that wraps the raster back to (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_base <= '0;
        end else if (hc == H_LAST) begin
            if (vc == V_LAST) begin
                row_base <= '0;
            end else if ((vc < V_VIS) && vc[0]) begin
                row_base <= row_base + FB_W;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fb_index <= '0;
            flags_d1     <= '0;
            flags_d2     <= '0;
        end else begin
            assert (fb_next < FB_SIZE);
            bus.fb_index <= fb_next;
            flags_d1     <= flags_now;
            flags_d2     <= flags_d1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
            bus.frame_start <= 1'b0;
            rgb_q           <= '0;
        end else begin
            bus.vga_hs      <= ~flags_d2.hs;
            bus.vga_vs      <= ~flags_d2.vs;
            bus.frame_start <= flags_d2.fs;
            if (flags_d2.pic) begin
                rgb_q <= rgb12_t'(bus.fb_data);
            end else if (flags_d2.vis) begin
                rgb_q <= BORDER;
            end else begin
                rgb_q <= '0;
            end
        end
    end

    assign bus.vga_r = rgb_q.r;
    assign bus.vga_g = rgb_q.g;
    assign bus.vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a 1-clock RAM whose content is address[11:0], a
// raster model computed from the pixel position arithmetic, a per-cycle
// compare of address and pins, sync/frame event checks and a table of
// hand-computed pixel/address values.
module tb_vga_scanout;

    localparam logic [11:0] BORDER_C = 12'hABC;
    localparam int          NLIT     = 21;

    typedef struct packed {
        logic [31:0] k;
        logic        is_rgb;
        logic [19:0] val;
    } lit_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     vectors = 0;
    int     errors = 0;
    bit     chk_en = 1'b0;

    lit_t        lits [NLIT];
    logic [14:0] pins;
    logic [19:0] exp_idx;
    logic [19:0] fb_max;
    bit          prev_hs, prev_vs, hs_fall_seen, vs_fall_seen;
    int          hs_low, vs_low, fs_count;
    longint      last_fs;

    vga_scanout_if bus ();

    vga_scanout #(.BORDER(BORDER_C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    always @(posedge clk) bus.fb_data <= bus.fb_index[11:0];

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
            if (errors >= 200) finish_run();
        end
    endtask

    // Address the picture pixel at raster position p must read.
    function automatic logic [19:0] model_index(input longint p);
        int x, y;
        x = int'(p % 800);
        y = int'((p / 800) % 525);
        if (y < 480 && x >= 64 && x <= 575) return 20'((y / 2) * 256 + (x - 64) / 2);
        return 20'd0;
    endfunction

    // {hs, vs, frame_start, rgb} expected on the pins k clocks after release.
    function automatic logic [14:0] model_pins(input longint k);
        longint      p;
        int          x, y;
        logic [19:0] idx;
        logic [11:0] rgb;
        logic        hs, vs, fs;
        if (k < 3) return 15'h6000;
        p   = k - 3;
        x   = int'(p % 800);
        y   = int'((p / 800) % 525);
        idx = model_index(p);
        if (x < 640 && y < 480) rgb = (x >= 64 && x <= 575) ? idx[11:0] : BORDER_C;
        else                    rgb = 12'h000;
        hs = !(x >= 656 && x <= 751);
        vs = !(y >= 490 && y <= 491);
        fs = (x == 0) && (y == 0);
        return {hs, vs, fs, rgb};
    endfunction

    task automatic set_lit(input int i, input int k, input bit is_rgb, input logic [19:0] val);
        lits[i] = '{k: 32'(k), is_rgb: is_rgb, val: val};
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            pins = {bus.vga_hs, bus.vga_vs, bus.frame_start, bus.vga_r, bus.vga_g, bus.vga_b};
            if (rst) begin
                chk("reset_index", 32'(bus.fb_index), 32'd0);
                chk("reset_pins", 32'(pins), 32'h6000);
                prev_hs = 1'b1; prev_vs = 1'b1;
                hs_fall_seen = 1'b0; vs_fall_seen = 1'b0;
                hs_low = 0; vs_low = 0; fs_count = 0;
                last_fs = -1; fb_max = '0;
            end else begin
                exp_idx = (cyc >= 1) ? model_index(cyc - 1) : 20'd0;
                chk("fb_index", 32'(bus.fb_index), 32'(exp_idx));
                chk("pins", 32'(pins), 32'(model_pins(cyc)));
                for (int i = 0; i < NLIT; i++) begin
                    if (cyc == longint'(lits[i].k)) begin
                        if (lits[i].is_rgb) chk("literal_rgb", 32'(pins[11:0]), 32'(lits[i].val));
                        else                chk("literal_index", 32'(bus.fb_index), 32'(lits[i].val));
                    end
                end
                if (bus.fb_index > fb_max) fb_max = bus.fb_index;

                if (prev_hs && !bus.vga_hs) begin
                    if (!hs_fall_seen) chk("first_hs_fall", 32'(cyc), 32'd659);
                    hs_fall_seen = 1'b1;
                    hs_low = 0;
                end
                if (!bus.vga_hs) hs_low++;
                if (!prev_hs && bus.vga_hs) chk("hs_low_width", 32'(hs_low), 32'd96);
                prev_hs = bus.vga_hs;

                if (prev_vs && !bus.vga_vs) begin
                    chk("vs_fall_cycle", 32'(cyc), 32'd392003);
                    vs_fall_seen = 1'b1;
                    vs_low = 0;
                end
                if (!bus.vga_vs) vs_low++;
                if (!prev_vs && bus.vga_vs) chk("vs_low_width", 32'(vs_low), 32'd1600);
                prev_vs = bus.vga_vs;

                if (bus.frame_start) begin
                    if (last_fs < 0) chk("first_frame_start", 32'(cyc), 32'd3);
                    else             chk("frame_period", 32'(cyc - last_fs), 32'd420000);
                    last_fs = cyc;
                    fs_count++;
                end
            end
        end
    end

    initial begin
        set_lit(0,  67,     1'b1, 20'h000);
        set_lit(1,  68,     1'b1, 20'h000);
        set_lit(2,  69,     1'b1, 20'h001);
        set_lit(3,  1667,   1'b1, 20'h100);
        set_lit(4,  3,      1'b1, 20'hABC);
        set_lit(5,  603,    1'b1, 20'hABC);
        set_lit(6,  642,    1'b1, 20'hABC);
        set_lit(7,  643,    1'b1, 20'h000);
        set_lit(8,  703,    1'b1, 20'h000);
        set_lit(9,  384013, 1'b1, 20'h000);
        set_lit(10, 65,     1'b0, 20'd0);
        set_lit(11, 67,     1'b0, 20'd1);
        set_lit(12, 64,     1'b0, 20'd0);
        set_lit(13, 577,    1'b0, 20'd0);
        set_lit(14, 865,    1'b0, 20'd0);
        set_lit(15, 1376,   1'b0, 20'd255);
        set_lit(16, 1665,   1'b0, 20'd256);
        set_lit(17, 2465,   1'b0, 20'd256);
        set_lit(18, 383776, 1'b0, 20'd61439);
        set_lit(19, 579,    1'b1, 20'hABC);
        set_lit(20, 578,    1'b1, 20'h0FF);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #5 rst = 1'b0;

        // Run into the frame, then reset asynchronously at vc=200, hc=300.
        while (cyc < 160300) @(negedge clk);
        #5 rst = 1'b1;
        #1;
        chk("async_reset_index", 32'(bus.fb_index), 32'd0);
        chk("async_reset_pins",
            32'({bus.vga_hs, bus.vga_vs, bus.frame_start, bus.vga_r, bus.vga_g, bus.vga_b}),
            32'h6000);
        repeat (3) @(negedge clk);
        #5 rst = 1'b0;

        // One full frame plus the start of the next.
        while (cyc < 421000) @(negedge clk);
        chk("frame_start_count", 32'(fs_count), 32'd2);
        chk("vs_fall_seen", 32'(vs_fall_seen), 32'd1);
        chk("fb_index_max", 32'(fb_max), 32'd61439);
        finish_run();
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read side of the 256×240 frame buffer: generates 640×480@60 VGA timing from the 25 MHz pixel clock, issues frame-buffer read addresses, and drives 12-bit RGB and sync to the pins. Each NES pixel is doubled in both axes to 512×480, centred horizontally with a 64-pixel border on each side. The block sits between the frame-buffer RAM read port (index in, 12-bit data out, one-cycle registered read) and the board VGA connector.

## Interface
- `H_VIS`, 640 — visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48 — horizontal porch and sync widths; line total 800
- `V_VIS`, 480 — visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33 — vertical porch and sync widths; frame total 525
- `H_OFF`, 64 — left border width; picture occupies x = 64..575
- `BORDER`, 12'h000 — {R,G,B} colour shown in the visible border
- `clk` in 1 — pixel clock, 25 MHz; all logic is on the rising edge
- `rst` in 1 — asynchronous, active-high reset
- `fb_index` out 20 — frame-buffer read address, 0..61439
- `fb_data` in 12 — frame-buffer word {R[3:0],G[3:0],B[3:0]}; valid one clock after `fb_index`
- `vga_hs` out 1 — horizontal sync, active low
- `vga_vs` out 1 — vertical sync, active low
- `vga_r`, `vga_g`, `vga_b` out 4 each — colour outputs
- `frame_start` out 1 — one-cycle pulse when pixel (0,0) is on the pins

## Operation
- **Counters:** `hc` counts 0..799 and wraps to 0. `vc` increments when `hc` wraps, counts 0..524, and wraps to 0.
- **Visible region:** `hc` < 640 and `vc` < 480.
- **Picture region:** visible, and 64 ≤ `hc` ≤ 575.
- **Sync windows:**
  - `hs` is active when `hc` is in 656..751.
  - `vs` is active when `vc` is in 490..491.
- **Address generation (no multiplier):**
  - `col` = (`hc` − 64) >> 1.
  - `row_base` resets to 0 at `vc` = 0 and adds 256 at the end of each odd visible line.
  - `fb_index` = `row_base` + `col` in the picture region; 0 elsewhere.
  - Line 479, x = 575 gives 61439.
- **Colour select, per pipelined pixel:**
  - picture region: `fb_data`
  - visible but outside picture: `BORDER`
  - blanking: 0
- **Width rules:**
  - `col` is 8 bits.
  - `row_base` is 16 bits, zero-extended to 20 bits.
  - Overflow is impossible inside the picture region.
- **Reset values:** `hc` = `vc` = 0, `row_base` = 0, `fb_index` = 0, `vga_hs` = `vga_vs` = 1, RGB = 0, `frame_start` = 0, all pipeline flags cleared.
- **Reset mid-frame:** everything returns to the reset values immediately; after release, scanning restarts at (0,0) on the next clock.

## Timing
- **Pipeline** (counter state at clock n):
  - `fb_index` is registered → valid during n+1.
  - The RAM registers its output → `fb_data` valid during n+2.
  - Output registers → pins during n+3.
- **Latency:** visible, picture and sync flags are delayed 3 clocks so sync, colour and `frame_start` stay aligned. End-to-end latency is exactly 3 clocks.
- **Sync timing at the pins:**
  - `vga_hs` low for 96 consecutive clocks per 800-clock line.
  - `vga_vs` low for exactly 2 × 800 clocks per 420 000-clock frame.
- **`frame_start`:** high for one clock, 3 clocks after `hc` = `vc` = 0.
- **Wrap:** the `hc` 799→0 and `vc` 524→0 transitions occur on the same edge with no extra cycle. `row_base` clears on that same edge.
- **Output timing:** all outputs are registered; there are no combinational paths from `fb_data` to the pins.

## Structure
- **Shared package:** timing constants (totals, sync start/end derived from the parameters), the `H_OFF` picture window, and the `rgb12_t` packed {r,g,b} type. The frame-buffer writer uses the same package for 256/240/61440.
- **Sub-module `vga_timing`:** holds `hc`/`vc`, sync, visible, and frame-start generation.
- **`vga_scanout`:** holds the address generator, flag delay pipeline, and colour mux.

## Test plan
- **Reset then run one frame:**
  - `frame_start` pulses every 420 000 clocks.
  - `vga_hs` falls 3 + 656 clocks after the first `frame_start`-aligned edge.
  - `vga_vs` low for 1600 clocks starting at line 490.
- **RAM model with 1-clock latency, content = address[11:0]:**
  - Pixels at pin x = 64, 65 on line 0 both show 12'h000.
  - Pin x = 66 shows 12'h001.
  - Line 2, x = 64 shows 12'h100 (index 256).
- **Address bounds:** across a full frame `fb_index` never exceeds 61439. It reaches 61439 exactly at `vc` = 479, `hc` = 575. It is 0 at all non-picture counts.
- **Border and blank colours with `BORDER` = 12'hABC:**
  - Pins show ABC for x = 0..63 and 576..639 on visible lines.
  - Pins show 0 during blanking (x ≥ 640 or line ≥ 480).
- **Reset mid-frame:**
  - Assert `rst` asynchronously at `vc` = 200, `hc` = 300. Outputs go to their reset values without waiting for a clock edge.
  - After release, `frame_start` appears 3 clocks later, and `fb_index` restarts from 0.
- **Line and frame wrap:**
  - `hc` goes 799→0 with `vc` 524→0 on the same edge.
  - No duplicated or skipped line.
  - `row_base` is 0 for lines 0–1 and 256 for lines 2–3.
